// File: rtl/pqc_accel_launch.sv
// pqc_accel_launch: serialises NTT/PWAM/Keccak launches from decoder request levels and returns held done levels
// ports: clk, rst_n (async, active-low); ntt_we/pwam_we/keccak_we request levels, pwam_mode sampled with pwam_we;
//   instr_adv releases DONE; *_fin unit completion pulses; *_start one-cycle launch pulses; pwam_mode_o latched mode;
//   *_done held completion levels; busy = not idle; pqc_err = watchdog fired on the current op
module pqc_accel_launch #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ntt_we,
  input  logic pwam_we,
  input  logic pwam_mode,
  input  logic keccak_we,
  input  logic instr_adv,
  input  logic ntt_fin,
  input  logic pwam_fin,
  input  logic keccak_fin,
  output logic ntt_start,
  output logic pwam_start,
  output logic pwam_mode_o,
  output logic keccak_start,
  output logic ntt_done,
  output logic pwam_done,
  output logic keccak_done,
  output logic busy,
  output logic pqc_err
);
  localparam int CNT_W = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [1:0] sel, sel_req;
  logic [2:0] start_q, done_q, fin;
  logic [CNT_W-1:0] cnt;
  logic any_we, fin_sel, tmo, accept;
  assign fin = {keccak_fin, pwam_fin, ntt_fin};
  assign fin_sel = fin[sel];
  assign any_we = ntt_we | pwam_we | keccak_we;
  assign sel_req = ntt_we ? 2'd0 : pwam_we ? 2'd1 : 2'd2;
  assign accept = state == IDLE && any_we;
  assign tmo = TIMEOUT_CYCLES != 0 && cnt == LAST;
  assign {keccak_start, pwam_start, ntt_start} = start_q;
  assign {keccak_done, pwam_done, ntt_done} = done_q;
  assign busy = state != IDLE;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = any_we ? LAUNCH : IDLE;
      LAUNCH:  state_nxt = RUN;
      RUN:     state_nxt = (fin_sel || tmo) ? DONE : RUN;
      default: state_nxt = instr_adv ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel <= 2'd0;
      start_q <= 3'b000;
      done_q <= 3'b000;
      cnt <= '0;
      pqc_err <= 1'b0;
      pwam_mode_o <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) sel <= sel_req;
      if (accept && sel_req == 2'd1) pwam_mode_o <= pwam_mode;
      start_q <= accept ? 3'b001 << sel_req : 3'b000;
      done_q <= state_nxt == DONE ? 3'b001 << sel : 3'b000;
      cnt <= state == LAUNCH ? '0 : (state == RUN && cnt != '1) ? cnt + CNT_W'(1) : cnt;
      // a fin arriving on the timeout cycle completes the op cleanly
      pqc_err <= state == LAUNCH ? 1'b0 : (state == RUN && !fin_sel && tmo) ? 1'b1 : pqc_err;
    end
  end
endmodule

// File: tb/tb_pqc_accel_launch.sv
// tb_pqc_accel_launch: randomized op-level checks of pqc_accel_launch against an arithmetic timing model
module tb_pqc_accel_launch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ntt_we = 1'b0, pwam_we = 1'b0, keccak_we = 1'b0, pwam_mode = 1'b0, instr_adv = 1'b0;
  logic ntt_fin = 1'b0, pwam_fin = 1'b0, keccak_fin = 1'b0;
  logic [2:0] st0, dn0, st1, dn1, o_st, o_dn;
  logic mo0, mo1, bz0, bz1, er0, er1, o_mo, o_bz, o_er;
  bit wd_sel = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  pqc_accel_launch u_dut (
    .clk(clk), .rst_n(rst_n), .ntt_we(ntt_we), .pwam_we(pwam_we), .pwam_mode(pwam_mode),
    .keccak_we(keccak_we), .instr_adv(instr_adv), .ntt_fin(ntt_fin), .pwam_fin(pwam_fin),
    .keccak_fin(keccak_fin), .ntt_start(st0[0]), .pwam_start(st0[1]), .pwam_mode_o(mo0),
    .keccak_start(st0[2]), .ntt_done(dn0[0]), .pwam_done(dn0[1]), .keccak_done(dn0[2]),
    .busy(bz0), .pqc_err(er0)
  );
  pqc_accel_launch #(.TIMEOUT_CYCLES(8)) u_wd (
    .clk(clk), .rst_n(rst_n), .ntt_we(ntt_we), .pwam_we(pwam_we), .pwam_mode(pwam_mode),
    .keccak_we(keccak_we), .instr_adv(instr_adv), .ntt_fin(ntt_fin), .pwam_fin(pwam_fin),
    .keccak_fin(keccak_fin), .ntt_start(st1[0]), .pwam_start(st1[1]), .pwam_mode_o(mo1),
    .keccak_start(st1[2]), .ntt_done(dn1[0]), .pwam_done(dn1[1]), .keccak_done(dn1[2]),
    .busy(bz1), .pqc_err(er1)
  );
  assign o_st = wd_sel ? st1 : st0;
  assign o_dn = wd_sel ? dn1 : dn0;
  assign o_mo = wd_sel ? mo1 : mo0;
  assign o_bz = wd_sel ? bz1 : bz0;
  assign o_er = wd_sel ? er1 : er0;
  task step;
    @(posedge clk);
    #1;
  endtask
  task do_reset;
    {ntt_we, pwam_we, keccak_we, pwam_mode, instr_adv, ntt_fin, pwam_fin, keccak_fin} = '0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask
  // One complete op seen from the IDLE cycle in which the request is raised.
  // Model: winner by priority; start in cycle 1; RUN from cycle 2; the selected fin at RUN index d
  // gives done at RUN index d+1 if d < timeout, otherwise the watchdog gives done at RUN index timeout.
  task op(input bit wd, input logic [2:0] we, input logic mode, input int fin_d, input int adv_wait);
    int to, dr;
    logic [1:0] s;
    logic [2:0] oh;
    logic exp_err;
    wd_sel = wd;
    to = wd ? 8 : 4096;
    s = we[0] ? 2'd0 : we[1] ? 2'd1 : 2'd2;
    oh = 3'b001 << s;
    exp_err = !(fin_d >= 0 && fin_d < to);
    dr = exp_err ? to : fin_d + 1;
    checks++;
    if ({o_bz, o_st, o_dn} !== 7'b0) begin
      errors++;
      $display("FAIL idle_entry busy/start/done got %b want 0", {o_bz, o_st, o_dn});
    end
    {keccak_we, pwam_we, ntt_we} = we;
    pwam_mode = mode;
    step();
    checks++;
    if ({o_bz, o_st, o_dn} !== {1'b1, oh, 3'b000}) begin
      errors++;
      $display("FAIL launch busy/start/done got %b want %b", {o_bz, o_st, o_dn}, {1'b1, oh, 3'b000});
    end
    if (s == 2'd1) begin
      checks++;
      if (o_mo !== mode) begin
        errors++;
        $display("FAIL launch_mode got %b want %b", o_mo, mode);
      end
    end
    pwam_mode = ~mode;
    step();
    for (int r = 0; r < dr; r++) begin
      checks++;
      if ({o_bz, o_st, o_dn} !== 7'b1000000) begin
        errors++;
        $display("FAIL run%0d busy/start/done got %b want 1000000", r, {o_bz, o_st, o_dn});
      end
      if (r == 0) begin
        checks++;
        if (o_er !== 1'b0) begin
          errors++;
          $display("FAIL run_err_cleared got %b want 0", o_er);
        end
      end
      if (s == 2'd1) begin
        checks++;
        if (o_mo !== mode) begin
          errors++;
          $display("FAIL run_mode got %b want %b", o_mo, mode);
        end
      end
      {keccak_fin, pwam_fin, ntt_fin} = (3'($urandom) & ~oh) | (r == fin_d ? oh : 3'b000);
      pwam_mode = 1'($urandom);
      step();
    end
    {keccak_we, pwam_we, ntt_we} = 3'b000;
    for (int k = 0; k <= adv_wait; k++) begin
      checks++;
      if ({o_bz, o_st, o_dn, o_er} !== {1'b1, 3'b000, oh, exp_err}) begin
        errors++;
        $display("FAIL done%0d busy/start/done/err got %b want %b", k, {o_bz, o_st, o_dn, o_er},
                 {1'b1, 3'b000, oh, exp_err});
      end
      if (s == 2'd1) begin
        checks++;
        if (o_mo !== mode) begin
          errors++;
          $display("FAIL done_mode got %b want %b", o_mo, mode);
        end
      end
      {keccak_we, pwam_we, ntt_we} = k < adv_wait ? 3'($urandom) : 3'b000;
      {keccak_fin, pwam_fin, ntt_fin} = 3'($urandom);
      instr_adv = k == adv_wait;
      step();
    end
    {keccak_we, pwam_we, ntt_we, keccak_fin, pwam_fin, ntt_fin, instr_adv} = '0;
    checks++;
    if ({o_bz, o_st, o_dn, o_er} !== {7'b0, exp_err}) begin
      errors++;
      $display("FAIL release busy/start/done/err got %b want %b", {o_bz, o_st, o_dn, o_er}, {7'b0, exp_err});
    end
  endtask
  task test_reset;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bz0, st0, dn0, er0, mo0, bz1, st1, dn1, er1, mo1} !== 20'b0) begin
      errors++;
      $display("FAIL reset outputs got %b want 0", {bz0, st0, dn0, er0, mo0, bz1, st1, dn1, er1, mo1});
    end
    step();
    rst_n = 1'b1;
  endtask
  task test_ntt_basic;
    do_reset();
    op(1'b0, 3'b001, 1'b0, 8, 2);
  endtask
  task test_pwam_mode;
    do_reset();
    op(1'b0, 3'b010, 1'b1, 4, 1);
    op(1'b0, 3'b010, 1'b0, 0, 0);
  endtask
  task test_priority;
    do_reset();
    op(1'b0, 3'b101, 1'b0, 3, 0);
    op(1'b0, 3'b100, 1'b0, 2, 1);
    op(1'b0, 3'b110, 1'b1, 1, 0);
  endtask
  task test_watchdog;
    do_reset();
    op(1'b1, 3'b100, 1'b0, -1, 1);
    op(1'b1, 3'b001, 1'b0, 2, 0);
    op(1'b1, 3'b001, 1'b0, 7, 0);
    op(1'b1, 3'b010, 1'b1, 8, 0);
  endtask
  task test_async_reset;
    do_reset();
    wd_sel = 1'b0;
    pwam_we = 1'b1;
    pwam_mode = 1'b1;
    step();
    step();
    step();
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bz0, st0, dn0, er0, mo0} !== 9'b0) begin
      errors++;
      $display("FAIL async_reset outputs got %b want 0", {bz0, st0, dn0, er0, mo0});
    end
    pwam_we = 1'b0;
    pwam_mode = 1'b0;
    step();
    rst_n = 1'b1;
    op(1'b0, 3'b001, 1'b0, 5, 0);
  endtask
  task test_random;
    for (int w = 0; w < 2; w++) begin
      do_reset();
      for (int n = 0; n < 15; n++)
        op(w[0], 3'($urandom_range(1, 7)), 1'($urandom), w == 1 ? $urandom_range(0, 11) : $urandom_range(0, 15),
           $urandom_range(0, 3));
    end
  endtask
  initial begin
    test_reset();
    test_ntt_basic();
    test_pwam_mode();
    test_priority();
    test_watchdog();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
